// File: rtl/mm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mm_pkg                                                     |
// | Description : Shared constants for the matrix-multiply sequencer and the |
// |               downstream multiply/add tree: matrix size, operand and     |
// |               accumulator widths, tree latency and FSM state encoding.   |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mm_pkg;

  localparam int MATRIX_SIZE  = 4;
  localparam int DATA_WIDTH   = 8;
  localparam int ADDER_WIDTH  = 16;
  // One multiplier stage plus a balanced adder tree of log2(N) levels.
  localparam int PIPE_LATENCY = 1 + $clog2(MATRIX_SIZE);

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mm_valid_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mm_valid_pipe                                              |
// | Description : DEPTH-stage delay line carrying a valid flag and the (row, |
// |               col) coordinates of an issued pair, so that they emerge in |
// |               step with the multiply/add tree result.                    |
// | Ports       : clk, rstb (async active-low)                               |
// |               in_valid/in_row/in_col   - stage 0 input                   |
// |               out_valid/out_row/out_col - last stage output              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mm_valid_pipe #(
  parameter int DEPTH = 3,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_row,
  input  logic [IDX_W-1:0] in_col,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_row,
  output logic [IDX_W-1:0] out_col
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [IDX_W-1:0] row_q [DEPTH];
  logic [IDX_W-1:0] row_d [DEPTH];
  logic [IDX_W-1:0] col_q [DEPTH];
  logic [IDX_W-1:0] col_d [DEPTH];

  always_comb begin
    valid_d[0] = in_valid;
    row_d[0]   = in_row;
    col_d[0]   = in_col;
    for (int s = 1; s < DEPTH; s++) begin
      valid_d[s] = valid_q[s-1];
      row_d[s]   = row_q[s-1];
      col_d[s]   = col_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      valid_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        row_q[s] <= '0;
        col_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < DEPTH; s++) begin
        row_q[s] <= row_d[s];
        col_q[s] <= col_d[s];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_row   = row_q[DEPTH-1];
  assign out_col   = col_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mat_mul_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mat_mul_sequencer                                          |
// | Description : Holds two NxN signed 8-bit matrices and streams every      |
// |               (row of A, column of B) pair to an external multiply/add   |
// |               tree, then collects the tree's dot products as C = A x B   |
// |               in row-major order.                                        |
// | Ports       : clk, rstb (async active-low)                               |
// |               ld_valid/ld_sel/ld_addr/ld_data - operand load (IDLE only) |
// |               start       - begin a multiplication                       |
// |               busy, done  - run status / one-cycle completion pulse      |
// |               row_out, col_out - operand vectors to the tree             |
// |               tree_result - dot product returned by the tree             |
// |               res_valid/res_row/res_col/res_data - one C element         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mat_mul_sequencer #(
  parameter int MATRIX_SIZE  = mm_pkg::MATRIX_SIZE,
  parameter int PIPE_LATENCY = 1 + $clog2(MATRIX_SIZE)
) (
  input  logic                                      clk,
  input  logic                                      rstb,
  input  logic                                      ld_valid,
  input  logic                                      ld_sel,
  input  logic [2*$clog2(MATRIX_SIZE)-1:0]          ld_addr,
  input  logic [mm_pkg::DATA_WIDTH-1:0]             ld_data,
  input  logic                                      start,
  output logic                                      busy,
  output logic [mm_pkg::DATA_WIDTH*MATRIX_SIZE-1:0] row_out,
  output logic [mm_pkg::DATA_WIDTH*MATRIX_SIZE-1:0] col_out,
  input  logic [mm_pkg::ADDER_WIDTH-1:0]            tree_result,
  output logic                                      res_valid,
  output logic [$clog2(MATRIX_SIZE)-1:0]            res_row,
  output logic [$clog2(MATRIX_SIZE)-1:0]            res_col,
  output logic [mm_pkg::ADDER_WIDTH-1:0]            res_data,
  output logic                                      done
);
  import mm_pkg::*;

  localparam int IDX_W  = $clog2(MATRIX_SIZE);
  localparam int ADDR_W = 2 * IDX_W;
  localparam int NN     = MATRIX_SIZE * MATRIX_SIZE;
  localparam int VEC_W  = DATA_WIDTH * MATRIX_SIZE;
  // The drain covers the register stage after the last issue, the tree
  // latency and the result register, so DONE lands one cycle after the
  // final res_valid.
  localparam int DRAIN_LEN = PIPE_LATENCY + 2;
  localparam int DRN_W     = $clog2(DRAIN_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NN - 1);
  localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_LEN - 1);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [DRN_W-1:0]      drain_q, drain_d;
  logic [DATA_WIDTH-1:0] a_q [NN];
  logic [DATA_WIDTH-1:0] a_d [NN];
  logic [DATA_WIDTH-1:0] b_q [NN];
  logic [DATA_WIDTH-1:0] b_d [NN];
  logic [VEC_W-1:0]      row_out_q, row_out_d, col_out_q, col_out_d;
  logic                  iss_valid_q, iss_valid_d;
  logic [IDX_W-1:0]      iss_row_q, iss_row_d, iss_col_q, iss_col_d;
  logic                  res_valid_q, res_valid_d;
  logic [IDX_W-1:0]      res_row_q, res_row_d, res_col_q, res_col_d;
  logic [ADDER_WIDTH-1:0] res_data_q, res_data_d;

  logic                  issue;
  logic [IDX_W-1:0]      issue_i, issue_j;
  logic                  tap_valid;
  logic [IDX_W-1:0]      tap_row, tap_col;

  // Operand storage: writable only while idle.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (ld_valid && (state_q == ST_IDLE)) begin
      if (ld_sel) b_d[ld_addr] = ld_data;
      else        a_d[ld_addr] = ld_data;
    end
  end

  // Sequencer FSM; cnt_q is the pair index k = i*N + j.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          cnt_d   = '0;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DRN_W'(1);
        if (drain_q == DRAIN_LAST) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign issue   = (state_q == ST_ISSUE);
  assign issue_i = cnt_q[ADDR_W-1:IDX_W];
  assign issue_j = cnt_q[IDX_W-1:0];

  // Row i of A and column j of B, element m in byte lane m; zero when idle.
  always_comb begin
    row_out_d   = '0;
    col_out_d   = '0;
    iss_valid_d = issue;
    iss_row_d   = issue ? issue_i : '0;
    iss_col_d   = issue ? issue_j : '0;
    if (issue) begin
      for (int m = 0; m < MATRIX_SIZE; m++) begin
        row_out_d[DATA_WIDTH*m +: DATA_WIDTH] = a_q[{issue_i, IDX_W'(m)}];
        col_out_d[DATA_WIDTH*m +: DATA_WIDTH] = b_q[{IDX_W'(m), issue_j}];
      end
    end
  end

  // Issue coordinates travel beside the tree so they arrive with its result.
  mm_valid_pipe #(
    .DEPTH (PIPE_LATENCY),
    .IDX_W (IDX_W)
  ) u_valid_pipe (
    .clk       (clk),
    .rstb      (rstb),
    .in_valid  (iss_valid_q),
    .in_row    (iss_row_q),
    .in_col    (iss_col_q),
    .out_valid (tap_valid),
    .out_row   (tap_row),
    .out_col   (tap_col)
  );

  always_comb begin
    res_valid_d = tap_valid;
    res_row_d   = tap_valid ? tap_row : '0;
    res_col_d   = tap_valid ? tap_col : '0;
    res_data_d  = tap_valid ? tree_result : '0;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      drain_q     <= '0;
      for (int e = 0; e < NN; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
      end
      row_out_q   <= '0;
      col_out_q   <= '0;
      iss_valid_q <= 1'b0;
      iss_row_q   <= '0;
      iss_col_q   <= '0;
      res_valid_q <= 1'b0;
      res_row_q   <= '0;
      res_col_q   <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      a_q         <= a_d;
      b_q         <= b_d;
      row_out_q   <= row_out_d;
      col_out_q   <= col_out_d;
      iss_valid_q <= iss_valid_d;
      iss_row_q   <= iss_row_d;
      iss_col_q   <= iss_col_d;
      res_valid_q <= res_valid_d;
      res_row_q   <= res_row_d;
      res_col_q   <= res_col_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign row_out   = row_out_q;
  assign col_out   = col_out_q;
  assign res_valid = res_valid_q;
  assign res_row   = res_row_q;
  assign res_col   = res_col_q;
  assign res_data  = res_data_q;

endmodule
`default_nettype wire
